ppm_symbol_decoder: RTL
=======================

// Module: ppm_symbol_decoder
// PURPOSE
//   Parametrised L-PPM demodulator: slices each symbol into 2**BITS_PER_SYM slots of SAMPLES_PER_SLOT clk16 cycles,
//   locates the single optical pulse and emits the slot index as a data symbol, flagging empty/multi-pulse erasures.
//   Symbols are packed MSB-first into WORD_BITS words behind a valid/ready output register.
//   Sits between the frame-sync FSM (drives state) and the byte/packet layer.
// PARAMETERS
//   BITS_PER_SYM      2  bits per PPM symbol; slots per symbol L = 2**BITS_PER_SYM (1..4)
//   SAMPLES_PER_SLOT  2  clk16 cycles per slot (>=1)
//   SAMPLE_PHASE      0  sample index within slot at which Din_reg is tested (0..SAMPLES_PER_SLOT-1)
//   WORD_BITS         8  packed word width; must be a multiple of BITS_PER_SYM
// PORTS
//   clk16       in   1             sample clock; all logic on rising edge
//   rst_n       in   1             asynchronous, active-low reset
//   Din         in   1             PPM line, active low (pulse = 0)
//   state       in   1             1 = frame active, decode; 0 = idle/abort
//   ovf_clr     in   1             1-cycle pulse, clears overflow
//   sym_data    out  BITS_PER_SYM  decoded slot index (0 when sym_err)
//   sym_valid   out  1             1-cycle strobe, symbol complete
//   sym_err     out  1             qualified by sym_valid: 0 or >=2 pulses in symbol
//   word_data   out  WORD_BITS     packed word, first symbol in MSBs
//   word_err    out  1             qualified by word_valid: >=1 erased symbol in word
//   word_valid  out  1             word register full
//   word_ready  in   1             consumer accepts word when word_valid & word_ready
//   overflow    out  1             sticky: a completed word was dropped
// BEHAVIOUR
//   Reset: all outputs, counters, packer and Din_reg = 0.
//   Din_reg <= ~Din every cycle regardless of state (1-cycle sync; all detection uses Din_reg).
//   Counters samp_cnt (0..SPS-1), slot_cnt (0..L-1): advance only while state=1, samp wraps into slot, slot wraps to 0.
//   state=0: samp_cnt, slot_cnt, pulse count, pack count forced to 0 next edge; partial symbol/word discarded,
//     no sym_valid; word register, word_valid, overflow untouched. Re-raising state starts a new symbol at slot 0.
//   Sample cycle: state=1 & samp_cnt==SAMPLE_PHASE. If Din_reg=1: first hit latches slot_cnt; hit count
//     saturates at 2.
//   End cycle: state=1, slot_cnt==L-1, samp_cnt==SPS-1 (its own sample counts if SAMPLE_PHASE==SPS-1).
//   Next cycle: sym_valid=1 for one cycle; sym_err = (hits!=1); sym_data = latched slot, or 0 if err;
//     hit count cleared for next symbol.
//   Back-to-back symbols: no dead cycles; symbol period = L*SPS cycles (8 at defaults).
//   Packer: each sym_valid shifts sym_data into shift register (left shift, new symbol in LSBs), err ORed into
//     word-err accumulator; after N = WORD_BITS/BITS_PER_SYM symbols the word completes (same cycle as Nth sym_valid).
//   Word completion, register empty or (word_valid & word_ready) same cycle: load word_data/word_err,
//     word_valid=1 next cycle (simultaneous handoff+load never overflows).
//   Word completion while word_valid=1 & word_ready=0: new word dropped, overflow=1 next cycle,
//     held word unchanged.
//   word_valid & word_ready without completion: word_valid=0 next cycle; word_data holds last value.
//   overflow: set by drop, cleared by ovf_clr; simultaneous set and clear -> set wins.
//   Reset mid-operation: immediate async clear of everything; first symbol starts at first state=1 cycle.
// TESTING (defaults: L=4, SPS=2, phase 0, WORD_BITS=8; "slot k pulse" = Din=0 across slot k's 2 cycles)
//   1 Assert rst_n=0 mid-word with word_valid=1 -> all outputs 0 immediately; after release no sym_valid until state=1.
//   2 state=1, pulse in slot 2 -> exactly 8 cycles/symbol, sym_valid one cycle, sym_data=2'b10, sym_err=0.
//   3 Symbol with no pulse -> sym_err=1, sym_data=0; pulses in slots 1 and 3 -> sym_err=1, sym_data=0.
//   4 Symbols 3,0,1,2, word_ready=1 -> word_data=8'hC6, word_err=0, word_valid one cycle; with symbol 2 erased
//     -> word_data=8'hC4, word_err=1.
//   5 word_ready=0, 8 more symbols -> first word held, overflow=1 after second word; ovf_clr -> 0;
//     word_ready pulse on completion cycle -> new word loaded, overflow stays 0.
//   6 Drop state during slot 2, raise later -> no sym_valid for aborted symbol, pack count restarts
//     (next 4 symbols form one word); repeat with SPS=4, SAMPLE_PHASE=2, BITS_PER_SYM=3 -> 32-cycle symbols decode 0..7.

Source files
------------

// File: rtl/ppm_symbol_decoder.sv
// rtl/ppm_symbol_decoder.sv - L-PPM slot demodulator with MSB-first word packer
//
// Purpose:
//   Splits each symbol period into 2**BITS_PER_SYM slots of SAMPLES_PER_SLOT
//   clk16 cycles. It tests the synchronised line once per slot and reports the
//   index of the single pulsed slot. Symbols with no pulse or more than one
//   pulse are flagged as erasures. Decoded symbols are packed MSB-first into
//   WORD_BITS-wide words, which are held in a valid/ready output register.
//
// Ports:
//   clk16       in   sample clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   Din         in   PPM line, active low (pulse = 0)
//   state       in   1 = frame active (decode), 0 = idle/abort
//   ovf_clr     in   one-cycle pulse, clears overflow
//   sym_data    out  decoded slot index (0 on erasure)
//   sym_valid   out  one-cycle strobe per completed symbol
//   sym_err     out  erasure flag, qualified by sym_valid
//   word_data   out  packed word, first symbol in the MSBs
//   word_err    out  word holds at least one erased symbol, qualified by word_valid
//   word_valid  out  word register full
//   word_ready  in   consumer takes the word when word_valid & word_ready
//   overflow    out  sticky: a completed word was dropped
module ppm_symbol_decoder #(
  parameter int BITS_PER_SYM     = 2,
  parameter int SAMPLES_PER_SLOT = 2,
  parameter int SAMPLE_PHASE     = 0,
  parameter int WORD_BITS        = 8
) (
  input  logic                    clk16,
  input  logic                    rst_n,
  input  logic                    Din,
  input  logic                    state,
  input  logic                    ovf_clr,
  output logic [BITS_PER_SYM-1:0] sym_data,
  output logic                    sym_valid,
  output logic                    sym_err,
  output logic [WORD_BITS-1:0]    word_data,
  output logic                    word_err,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    overflow
);

  localparam int N_SYMS = WORD_BITS / BITS_PER_SYM;
  localparam int SW     = (SAMPLES_PER_SLOT > 1) ? $clog2(SAMPLES_PER_SLOT) : 1;
  localparam int PW     = (N_SYMS > 1) ? $clog2(N_SYMS) : 1;

  localparam logic [SW-1:0]           SAMP_LAST = SW'(SAMPLES_PER_SLOT - 1);
  localparam logic [SW-1:0]           SAMP_TEST = SW'(SAMPLE_PHASE);
  localparam logic [BITS_PER_SYM-1:0] SLOT_LAST = '1;
  localparam logic [PW-1:0]           PACK_LAST = PW'(N_SYMS - 1);

  logic                    din_reg_q;
  logic [SW-1:0]           samp_cnt_q, samp_cnt_d;
  logic [BITS_PER_SYM-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]              hits_q, hits_d;
  logic [BITS_PER_SYM-1:0] slot_lat_q, slot_lat_d;
  logic                    sym_valid_q, sym_valid_d;
  logic [BITS_PER_SYM-1:0] sym_data_q, sym_data_d;
  logic                    sym_err_q, sym_err_d;
  logic [PW-1:0]           pack_cnt_q, pack_cnt_d;
  logic [WORD_BITS-1:0]    shreg_q, shreg_d;
  logic                    acc_err_q, acc_err_d;
  logic [WORD_BITS-1:0]    word_data_q, word_data_d;
  logic                    word_err_q, word_err_d;
  logic                    word_valid_q, word_valid_d;
  logic                    overflow_q, overflow_d;

  logic                    sample_hit, end_cycle, word_done, drop;
  logic [1:0]              hits_now;
  logic [BITS_PER_SYM-1:0] slot_now;
  logic [WORD_BITS-1:0]    packed_word;

  always_comb begin
    samp_cnt_d   = samp_cnt_q;
    slot_cnt_d   = slot_cnt_q;
    hits_d       = hits_q;
    slot_lat_d   = slot_lat_q;
    sym_valid_d  = 1'b0;
    sym_data_d   = sym_data_q;
    sym_err_d    = sym_err_q;
    pack_cnt_d   = pack_cnt_q;
    shreg_d      = shreg_q;
    acc_err_d    = acc_err_q;
    word_data_d  = word_data_q;
    word_err_d   = word_err_q;
    word_valid_d = word_valid_q;
    overflow_d   = overflow_q;

    sample_hit = state && (samp_cnt_q == SAMP_TEST) && din_reg_q;
    end_cycle  = state && (slot_cnt_q == SLOT_LAST) && (samp_cnt_q == SAMP_LAST);

    // Hit tally including this cycle's sample, so a sample on the end cycle
    // still counts toward the symbol that is closing.
    hits_now = hits_q;
    slot_now = slot_lat_q;
    if (sample_hit) begin
      if (hits_q == 2'd0) slot_now = slot_cnt_q;
      if (hits_q != 2'd2) hits_now = hits_q + 2'd1;
    end

    if (!state) begin
      samp_cnt_d = '0;
      slot_cnt_d = '0;
      hits_d     = 2'd0;
    end else if (end_cycle) begin
      samp_cnt_d  = '0;
      slot_cnt_d  = '0;
      hits_d      = 2'd0;
      sym_valid_d = 1'b1;
      sym_err_d   = (hits_now != 2'd1);
      sym_data_d  = (hits_now == 2'd1) ? slot_now : '0;
    end else begin
      hits_d     = hits_now;
      slot_lat_d = slot_now;
      if (samp_cnt_q == SAMP_LAST) begin
        samp_cnt_d = '0;
        slot_cnt_d = slot_cnt_q + BITS_PER_SYM'(1);
      end else begin
        samp_cnt_d = samp_cnt_q + SW'(1);
      end
    end

    // The upper symbol slot of shreg_q is stale by the time the word closes,
    // so it is shifted out here rather than cleared between words.
    packed_word = WORD_BITS'(shreg_q << BITS_PER_SYM) | WORD_BITS'(sym_data_q);
    word_done   = sym_valid_q && (pack_cnt_q == PACK_LAST);
    drop        = word_done && word_valid_q && !word_ready;

    // A word that closes on the cycle state falls is complete, not partial,
    // so it is still delivered; only unfinished words are discarded.
    if (word_done || !state) begin
      pack_cnt_d = '0;
      acc_err_d  = 1'b0;
    end else if (sym_valid_q) begin
      pack_cnt_d = pack_cnt_q + PW'(1);
      shreg_d    = packed_word;
      acc_err_d  = acc_err_q | sym_err_q;
    end

    if (word_done) begin
      if (!drop) begin
        word_data_d  = packed_word;
        word_err_d   = acc_err_q | sym_err_q;
        word_valid_d = 1'b1;
      end
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      din_reg_q    <= 1'b0;
      samp_cnt_q   <= '0;
      slot_cnt_q   <= '0;
      hits_q       <= 2'd0;
      slot_lat_q   <= '0;
      sym_valid_q  <= 1'b0;
      sym_data_q   <= '0;
      sym_err_q    <= 1'b0;
      pack_cnt_q   <= '0;
      shreg_q      <= '0;
      acc_err_q    <= 1'b0;
      word_data_q  <= '0;
      word_err_q   <= 1'b0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      din_reg_q    <= ~Din;
      samp_cnt_q   <= samp_cnt_d;
      slot_cnt_q   <= slot_cnt_d;
      hits_q       <= hits_d;
      slot_lat_q   <= slot_lat_d;
      sym_valid_q  <= sym_valid_d;
      sym_data_q   <= sym_data_d;
      sym_err_q    <= sym_err_d;
      pack_cnt_q   <= pack_cnt_d;
      shreg_q      <= shreg_d;
      acc_err_q    <= acc_err_d;
      word_data_q  <= word_data_d;
      word_err_q   <= word_err_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sym_valid  = sym_valid_q;
  assign sym_data   = sym_data_q;
  assign sym_err    = sym_err_q;
  assign word_data  = word_data_q;
  assign word_err   = word_err_q;
  assign word_valid = word_valid_q;
  assign overflow   = overflow_q;

endmodule
